// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and byte sequencer sharing one byte-wide synchronous SRAM
// between the CPU load/store port (A) and a secondary master (B).
module data_mem_arbiter #(
  parameter int MEM_BYTES = 2000,
  parameter int ADDR_W    = 11
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iAReq,
  input  logic              iAWrite,
  input  logic [31:0]       iAAddr,
  input  logic [31:0]       iAWData,
  input  logic [2:0]        iAFunct3,
  input  logic              iBReq,
  input  logic              iBWrite,
  input  logic [31:0]       iBAddr,
  input  logic [31:0]       iBWData,
  input  logic [2:0]        iBFunct3,
  output logic              oADone,
  output logic              oAErr,
  output logic [31:0]       oARData,
  output logic              oBDone,
  output logic              oBErr,
  output logic [31:0]       oBRData,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [7:0]        oMemWData,
  output logic              oMemWe,
  output logic              oMemRe,
  input  logic [7:0]        iMemRData,
  output logic              oBusy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_b;
  logic               r_owner_b;
  logic               r_write;
  logic               r_err;
  logic [2:0]         r_k;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_buf;
  logic [2:0]         r_funct3;

  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_grant;
  logic               w_sel_write;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [2:0]         w_sel_funct3;
  logic               w_sel_err;
  logic [2:0]         w_n;
  logic [2:0]         w_nm1;
  logic               w_last_byte;
  logic [1:0]         w_cap_sel;
  logic [7:0]         w_wbyte;
  logic [31:0]        w_rdata;

  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic req_error(input logic wr, input logic [31:0] addr,
                                     input logic [2:0] f3);
    logic [32:0] end_addr;
    logic        bad;
    end_addr = {1'b0, addr} + {30'd0, byte_count(f3)};
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    if (wr && (f3 == 3'b100 || f3 == 3'b101)) bad = 1'b1;
    if (f3[1:0] == 2'b01 && addr[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
    if (end_addr > 33'(MEM_BYTES)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] b);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b001:  return {{16{b[15]}}, b[15:0]};
      3'b100:  return {24'd0, b[7:0]};
      3'b101:  return {16'd0, b[15:0]};
      default: return b;
    endcase
  endfunction

  // On a tie the port that was not granted last wins
  assign w_grant_a    = iAReq & (~iBReq | r_last_b);
  assign w_grant_b    = iBReq & ~w_grant_a;
  assign w_grant      = w_grant_a | w_grant_b;
  assign w_sel_write  = w_grant_b ? iBWrite  : iAWrite;
  assign w_sel_addr   = w_grant_b ? iBAddr   : iAAddr;
  assign w_sel_wdata  = w_grant_b ? iBWData  : iAWData;
  assign w_sel_funct3 = w_grant_b ? iBFunct3 : iAFunct3;
  assign w_sel_err    = req_error(w_sel_write, w_sel_addr, w_sel_funct3);

  assign w_n         = byte_count(r_funct3);
  assign w_nm1       = w_n - 3'd1;
  assign w_last_byte = (r_k == w_nm1);
  assign w_wbyte     = r_wdata[{r_k[1:0], 3'b000} +: 8];
  // Read data trails its strobe by one cycle, so byte k-1 lands while k is issued
  assign w_cap_sel   = (r_state == DRAIN) ? w_nm1[1:0] : (r_k[1:0] - 2'd1);
  assign oBusy       = (r_state != IDLE);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_k       <= 3'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_last_b  <= w_grant_b;
            r_owner_b <= w_grant_b;
            r_write   <= w_sel_write;
            r_err     <= w_sel_err;
            r_k       <= 3'd0;
          end
        end
        ACCESS:  r_k <= r_k + 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (r_state == IDLE && w_grant) begin
      r_addr   <= w_sel_addr[ADDR_W-1:0];
      r_wdata  <= w_sel_wdata;
      r_funct3 <= w_sel_funct3;
      r_buf    <= 32'd0;
    end else if ((r_state == ACCESS && !r_write && r_k != 3'd0) || r_state == DRAIN) begin
      r_buf[{w_cap_sel, 3'b000} +: 8] <= iMemRData;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = w_sel_err ? RESP : ACCESS;
      ACCESS:  if (w_last_byte) w_next = r_write ? RESP : DRAIN;
      DRAIN:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    oMemAddr  = '0;
    oMemWData = 8'd0;
    oMemWe    = 1'b0;
    oMemRe    = 1'b0;
    oADone    = 1'b0;
    oAErr     = 1'b0;
    oARData   = 32'd0;
    oBDone    = 1'b0;
    oBErr     = 1'b0;
    oBRData   = 32'd0;
    w_rdata   = (r_write || r_err) ? 32'd0 : extend(r_funct3, r_buf);
    if (r_state == ACCESS) begin
      oMemAddr = r_addr + ADDR_W'(r_k);
      if (r_write) begin
        oMemWe    = 1'b1;
        oMemWData = w_wbyte;
      end else begin
        oMemRe = 1'b1;
      end
    end
    if (r_state == RESP) begin
      if (r_owner_b) begin
        oBDone  = 1'b1;
        oBErr   = r_err;
        oBRData = w_rdata;
      end else begin
        oADone  = 1'b1;
        oAErr   = r_err;
        oARData = w_rdata;
      end
    end
  end

endmodule
